// File: rtl/mr_arb_pkg.sv
// rtl/mr_arb_pkg.sv - shared types and helpers for the round-robin Wishbone arbiter
package mr_arb_pkg;

    localparam int ARB_MAX_N = 8;
    localparam int OWNER_W   = $clog2(ARB_MAX_N);

    typedef enum logic {
        ARB_IDLE,
        ARB_OWNED
    } arb_state_e;

    typedef logic [OWNER_W-1:0] owner_idx_t;

    function automatic owner_idx_t onehot_to_idx(input logic [ARB_MAX_N-1:0] oh);
        owner_idx_t idx;
        idx = '0;
        for (int i = 0; i < ARB_MAX_N; i++) begin
            if (oh[i]) begin
                idx = idx | owner_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mr_rr_picker.sv
// rtl/mr_rr_picker.sv - combinational round-robin pick starting after the last owner
module mr_rr_picker
    import mr_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0] i_req,
    input  owner_idx_t   i_last_owner,
    output logic [N-1:0] o_onehot,
    output logic         o_valid
);

    // First pass covers indices above the last owner, second pass wraps to the bottom.
    always_comb begin
        o_onehot = '0;
        o_valid  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!o_valid && i_req[i] && (i > int'(i_last_owner))) begin
                o_onehot[i] = 1'b1;
                o_valid     = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!o_valid && i_req[i] && (i <= int'(i_last_owner))) begin
                o_onehot[i] = 1'b1;
                o_valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mr_wb_rr_arbiter.sv
// rtl/mr_wb_rr_arbiter.sv - N:1 pipelined Wishbone round-robin arbiter (optional watchdog: MR_ARB_TIMEOUT_EN)
module mr_wb_rr_arbiter
    import mr_arb_pkg::*;
#(
    parameter int NUM_MASTERS     = 2,
    parameter int AW              = 32,
    parameter int DW              = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_MASTERS-1:0]      m_cyc,
    input  logic [NUM_MASTERS-1:0]      m_stb,
    input  logic [NUM_MASTERS-1:0]      m_we,
    input  logic [NUM_MASTERS*AW-1:0]   m_adr,
    input  logic [NUM_MASTERS*DW-1:0]   m_dat_w,
    input  logic [NUM_MASTERS*DW/8-1:0] m_sel,
    output logic [NUM_MASTERS-1:0]      m_ack,
    output logic [NUM_MASTERS-1:0]      m_err,
    output logic [NUM_MASTERS-1:0]      m_stall,
    output logic                        s_cyc,
    output logic                        s_stb,
    output logic                        s_we,
    output logic [AW-1:0]               s_adr,
    output logic [DW-1:0]               s_dat_w,
    output logic [DW/8-1:0]             s_sel,
    input  logic                        s_ack,
    input  logic                        s_err,
    input  logic                        s_stall,
    output logic [NUM_MASTERS-1:0]      grant,
    output logic                        timeout
);

    localparam int SW = DW / 8;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    arb_state_e             r_state, w_nxt_state;
    logic [NUM_MASTERS-1:0] r_grant, w_nxt_grant;
    owner_idx_t             r_last, w_nxt_last;
    logic [CW-1:0]          r_outst, w_nxt_outst;

    logic [NUM_MASTERS-1:0] w_pick_oh;
    logic                   w_pick_valid;
    logic                   w_full;
    logic                   w_own_stall;
    logic                   w_accept;
    logic                   w_resp_ok;
    logic                   w_resp;
    logic                   w_wd_fire;

    mr_rr_picker #(
        .N (NUM_MASTERS)
    ) u_picker (
        .i_req        (m_cyc),
        .i_last_owner (r_last),
        .o_onehot     (w_pick_oh),
        .o_valid      (w_pick_valid)
    );

    // AND-OR mux on the one-hot grant; a zero grant drives the slave bus to all zeros.
    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            s_cyc   = s_cyc | (m_cyc[i] & r_grant[i]);
            s_stb   = s_stb | (m_stb[i] & r_grant[i]);
            s_we    = s_we  | (m_we[i]  & r_grant[i]);
            s_adr   = s_adr   | (m_adr[i*AW +: AW]   & {AW{r_grant[i]}});
            s_dat_w = s_dat_w | (m_dat_w[i*DW +: DW] & {DW{r_grant[i]}});
            s_sel   = s_sel   | (m_sel[i*SW +: SW]   & {SW{r_grant[i]}});
        end
    end

    assign w_full      = (r_outst == CW'(MAX_OUTSTANDING));
    assign w_own_stall = s_stall | w_full;
    assign w_accept    = s_cyc & s_stb & ~w_own_stall;
    assign w_resp_ok   = (r_outst != '0);
    assign w_resp      = (s_ack | s_err) & w_resp_ok;

    assign m_stall = ~r_grant | (r_grant & {NUM_MASTERS{w_own_stall}});
    assign m_ack   = r_grant & {NUM_MASTERS{s_ack & w_resp_ok}};
    assign m_err   = r_grant & {NUM_MASTERS{(s_err & w_resp_ok) | w_wd_fire}};
    assign grant   = r_grant;

`ifdef MR_ARB_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WD_W-1:0] r_wd;
    logic            r_timeout;
    logic            w_wd_cnt;

    assign w_wd_cnt  = (r_state == ARB_OWNED) & w_resp_ok & ~s_ack & ~s_err;
    assign w_wd_fire = w_wd_cnt & (r_wd == WD_W'(TIMEOUT_CYCLES - 1));
    assign timeout   = r_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd      <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_wd <= (w_wd_cnt && !w_wd_fire) ? r_wd + WD_W'(1) : '0;
            if (w_wd_fire) begin
                r_timeout <= 1'b1;
            end
        end
    end
`else
    assign w_wd_fire = 1'b0;
    assign timeout   = 1'b0;
`endif

    // Ownership only moves through IDLE, so responses in flight never reach a new owner.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_grant = r_grant;
        w_nxt_last  = r_last;
        w_nxt_outst = r_outst;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    w_nxt_grant = w_pick_oh;
                    w_nxt_state = ARB_OWNED;
                end
            end
            ARB_OWNED: begin
                if (!s_cyc) begin
                    w_nxt_state = ARB_IDLE;
                    w_nxt_grant = '0;
                    w_nxt_last  = onehot_to_idx(ARB_MAX_N'(r_grant));
                    w_nxt_outst = '0;
                end else if (w_wd_fire) begin
                    w_nxt_outst = '0;
                end else if (w_accept && !w_resp) begin
                    w_nxt_outst = r_outst + CW'(1);
                end else if (!w_accept && w_resp) begin
                    w_nxt_outst = r_outst - CW'(1);
                end
            end
            default: w_nxt_state = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_last  <= owner_idx_t'(NUM_MASTERS - 1);
            r_outst <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_grant <= w_nxt_grant;
            r_last  <= w_nxt_last;
            r_outst <= w_nxt_outst;
        end
    end

endmodule

// File: tb/tb_mr_wb_rr_arbiter.sv
// tb/tb_mr_wb_rr_arbiter.sv - directed vector bench for mr_wb_rr_arbiter
module tb_mr_wb_rr_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
`ifdef MR_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 256;
`endif
    localparam int NV = 30;

    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] A1 = 32'h0000_2000;
    localparam logic [31:0] Z  = 32'h0000_0000;

    logic            clk;
    logic            rst;
    logic [N-1:0]    m_cyc, m_stb, m_we;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat_w;
    logic [N*SW-1:0] m_sel;
    logic [N-1:0]    m_ack, m_err, m_stall;
    logic            s_cyc, s_stb, s_we;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_dat_w;
    logic [SW-1:0]   s_sel;
    logic            s_ack, s_err, s_stall;
    logic [N-1:0]    grant;
    logic            timeout;

    mr_wb_rr_arbiter #(
        .NUM_MASTERS     (N),
        .AW              (AW),
        .DW              (DW),
        .MAX_OUTSTANDING (4),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_cyc   (m_cyc),
        .m_stb   (m_stb),
        .m_we    (m_we),
        .m_adr   (m_adr),
        .m_dat_w (m_dat_w),
        .m_sel   (m_sel),
        .m_ack   (m_ack),
        .m_err   (m_err),
        .m_stall (m_stall),
        .s_cyc   (s_cyc),
        .s_stb   (s_stb),
        .s_we    (s_we),
        .s_adr   (s_adr),
        .s_dat_w (s_dat_w),
        .s_sel   (s_sel),
        .s_ack   (s_ack),
        .s_err   (s_err),
        .s_stall (s_stall),
        .grant   (grant),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  cyc;
        logic [1:0]  stb;
        logic        ack;
        logic        err;
        logic        stall;
        logic [1:0]  e_grant;
        logic [1:0]  e_ack;
        logic [1:0]  e_err;
        logic [1:0]  e_stall;
        logic        e_scyc;
        logic        e_sstb;
        logic        e_we;
        logic [31:0] e_adr;
    } vec_t;

    vec_t vt[NV];

    function automatic vec_t v(input logic [1:0] cyc, input logic [1:0] stb,
                               input logic ack, input logic err, input logic stall,
                               input logic [1:0] g, input logic [1:0] a, input logic [1:0] e,
                               input logic [1:0] st, input logic sc, input logic ss,
                               input logic we, input logic [31:0] adr);
        vec_t r;
        r.cyc = cyc; r.stb = stb; r.ack = ack; r.err = err; r.stall = stall;
        r.e_grant = g; r.e_ack = a; r.e_err = e; r.e_stall = st;
        r.e_scyc = sc; r.e_sstb = ss; r.e_we = we; r.e_adr = adr;
        return r;
    endfunction

    initial begin
        //          cyc    stb    ack   err   stl  | grant  ack    err    stall  scyc  sstb  we    adr
        vt[0]  = v(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, Z);
        vt[1]  = v(2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, A0);
        vt[2]  = v(2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, A0);
        vt[3]  = v(2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, A0);
        vt[4]  = v(2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, A0);
        vt[5]  = v(2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b11, 1'b1, 1'b1, 1'b0, A0);
        vt[6]  = v(2'b11, 2'b01, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b11, 1'b1, 1'b1, 1'b0, A0);
        vt[7]  = v(2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, A0);
        vt[8]  = v(2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0, A0);
        vt[9]  = v(2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, A0);
        vt[10] = v(2'b11, 2'b01, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, A0);
        vt[11] = v(2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, A0);
        vt[12] = v(2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0, A0);
        vt[13] = v(2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, A0);
        vt[14] = v(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, A0);
        vt[15] = v(2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, Z);
        vt[16] = v(2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b01, 1'b1, 1'b1, 1'b1, A1);
        vt[17] = v(2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b01, 1'b1, 1'b1, 1'b1, A1);
        vt[18] = v(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, A1);
        vt[19] = v(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, Z);
        vt[20] = v(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, Z);
        vt[21] = v(2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, A0);
        vt[22] = v(2'b11, 2'b01, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b11, 1'b1, 1'b1, 1'b0, A0);
        vt[23] = v(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, A0);
        vt[24] = v(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, Z);
        vt[25] = v(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 1'b1, A1);
        vt[26] = v(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, A1);
        vt[27] = v(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, Z);
        vt[28] = v(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, A0);
        vt[29] = v(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, Z);

        rst     = 1'b1;
        m_cyc   = '0;
        m_stb   = '0;
        m_we    = 2'b10;
        m_adr   = {A1, A0};
        m_dat_w = {32'hBBBB_0001, 32'hAAAA_0000};
        m_sel   = {4'b1100, 4'b0011};
        s_ack   = 1'b0;
        s_err   = 1'b0;
        s_stall = 1'b0;

        #12;
        chk("rst.grant", grant, 2'b00);
        chk("rst.m_stall", m_stall, 2'b11);
        chk("rst.m_ack", m_ack, 2'b00);
        chk("rst.s_cyc", s_cyc, 1'b0);
        chk("rst.s_adr", s_adr, Z);
        chk("rst.timeout", timeout, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            m_cyc   = vt[i].cyc;
            m_stb   = vt[i].stb;
            s_ack   = vt[i].ack;
            s_err   = vt[i].err;
            s_stall = vt[i].stall;
            #2;
            chk($sformatf("v%0d.grant", i), grant, vt[i].e_grant);
            chk($sformatf("v%0d.m_ack", i), m_ack, vt[i].e_ack);
            chk($sformatf("v%0d.m_err", i), m_err, vt[i].e_err);
            chk($sformatf("v%0d.m_stall", i), m_stall, vt[i].e_stall);
            chk($sformatf("v%0d.s_cyc", i), s_cyc, vt[i].e_scyc);
            chk($sformatf("v%0d.s_stb", i), s_stb, vt[i].e_sstb);
            chk($sformatf("v%0d.s_we", i), s_we, vt[i].e_we);
            chk($sformatf("v%0d.s_adr", i), s_adr, vt[i].e_adr);
            chk($sformatf("v%0d.onehot0", i), $onehot0(grant), 1'b1);
        end

        // async reset mid-tenure
        @(posedge clk); #1 m_cyc = 2'b01; s_ack = 1'b0; s_err = 1'b0; s_stall = 1'b0;
        @(posedge clk); #1 m_stb = 2'b01;
        @(posedge clk); #1 m_stb = 2'b00;
        #1 rst = 1'b1;
        #1;
        chk("arst.grant", grant, 2'b00);
        chk("arst.m_stall", m_stall, 2'b11);
        chk("arst.s_cyc", s_cyc, 1'b0);
        @(posedge clk); #1 rst = 1'b0; m_cyc = 2'b10;
        @(posedge clk); #1 s_ack = 1'b1;
        #2;
        chk("m1.grant", grant, 2'b10);
        chk("m1.s_dat_w", s_dat_w, 32'hBBBB_0001);
        chk("m1.s_sel", s_sel, 4'b1100);
        chk("m1.s_we", s_we, 1'b1);
        chk("m1.ack_after_rst", m_ack, 2'b00);

        // single accept, silent slave
        @(posedge clk); #1 s_ack = 1'b0; m_stb = 2'b10;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1 m_stb = 2'b00;
            #2;
`ifdef MR_ARB_TIMEOUT_EN
            chk($sformatf("wd%0d.m_err", k), m_err, (k == 8) ? 2'b10 : 2'b00);
`else
            chk($sformatf("wd%0d.m_err", k), m_err, 2'b00);
`endif
        end
        @(posedge clk); #3;
        chk("wd.m_err_after", m_err, 2'b00);
`ifdef MR_ARB_TIMEOUT_EN
        chk("wd.timeout", timeout, 1'b1);
`else
        chk("wd.timeout", timeout, 1'b0);
`endif
        @(posedge clk); #1 s_ack = 1'b1;
        #2;
`ifdef MR_ARB_TIMEOUT_EN
        chk("wd.late_ack", m_ack, 2'b00);
`else
        chk("wd.late_ack", m_ack, 2'b10);
`endif
        @(posedge clk); #1 s_ack = 1'b0; m_cyc = 2'b00;
        @(posedge clk); #1 rst = 1'b1;
        #2;
        chk("wd.timeout_rst", timeout, 1'b0);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
